aes_iter_ctrl: RTL and testbench

// - Iterative AES-128 encryption controller: one shared round datapath, sequenced over 10 rounds (one round/clk).
// - Replaces the fully unrolled 10-round combinational encryptor wherever area beats latency (ticket/ID encryption).
// - Valid/ready on input and output; owns the FSM, round counter, state register and on-the-fly key schedule.

---
 rtl/aes_pkg.sv | 67 ++++++
 rtl/aes_key_step.sv | 23 ++
 rtl/aes_round_ops.sv | 48 ++++
 rtl/aes_iter_ctrl.sv | 98 +++++++++
 tb/tb_aes_iter_ctrl.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller FSM states, round constants and
// byte-level GF(2^8) helpers used by the round datapath and key schedule.
package aes_pkg;

   localparam int AES_BLK_W = 128;
   localparam int NR        = 10;
   localparam int CNT_W     = 4;
   localparam logic [CNT_W-1:0] LAST_RND = CNT_W'(NR);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } state_e;

   // Round constant for rounds 1..10; anything else yields zero.
   function automatic logic [7:0] rcon(input logic [CNT_W-1:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // S-box built from its definition: inverse (a^254, maps 0 to 0) then the
   // affine transform. Avoids carrying a 256-entry table in the source.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] inv;
      logic [7:0] e;
      inv = 8'h01;
      e   = 8'hfe;
      for (int i = 7; i >= 0; i--) begin
         inv = gf_mul(inv, inv);
         if (e[i]) inv = gf_mul(inv, a);
      end
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_step.sv
// Next AES-128 round key from the current one: RotWord, SubWord and rcon on
// the last word, then the XOR chain across the four words.
module aes_key_step
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] key_i,
   input  logic [7:0]           rcon_i,
   output logic [AES_BLK_W-1:0] key_o
);
   logic [31:0] w0, w1, w2, w3, t, n0, n1, n2, n3;

   assign {w0, w1, w2, w3} = key_i;

   // w3 rotated left one byte, each byte substituted, rcon into the top byte.
   assign t = {sbox(w3[23:16]) ^ rcon_i, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};

   assign n0 = w0 ^ t;
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign key_o = {n0, n1, n2, n3};
endmodule

// File: rtl/aes_round_ops.sv
// AES round transforms on a 128-bit block, byte 0 in [127:120], state laid
// out column-major (byte index = row + 4*col).

// SubBytes: one S-box per byte lane.
module sub_byte
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] d_i,
   output logic [AES_BLK_W-1:0] d_o
);
   for (genvar i = 0; i < 16; i++) begin : g_byte
      assign d_o[8*i +: 8] = sbox(d_i[8*i +: 8]);
   end
endmodule

// ShiftRows: row r rotates left by r columns.
module shift_row
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] d_i,
   output logic [AES_BLK_W-1:0] d_o
);
   for (genvar r = 0; r < 4; r++) begin : g_row
      for (genvar c = 0; c < 4; c++) begin : g_col
         assign d_o[127-8*(r+4*c) -: 8] = d_i[127-8*(r+4*((c+r)%4)) -: 8];
      end
   end
endmodule

// MixColumns: each column multiplied by the fixed {02,03,01,01} circulant.
module mix_col
   import aes_pkg::*;
(
   input  logic [AES_BLK_W-1:0] d_i,
   output logic [AES_BLK_W-1:0] d_o
);
   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = d_i[127-32*c -: 8];
      assign a1 = d_i[119-32*c -: 8];
      assign a2 = d_i[111-32*c -: 8];
      assign a3 = d_i[103-32*c -: 8];
      assign d_o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      assign d_o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      assign d_o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      assign d_o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
   end
endmodule

// File: rtl/aes_iter_ctrl.sv
// Iterative AES-128 encryptor: one shared round datapath applied once per
// clock over 10 rounds, with the round key derived on the fly.
// Optional feature macro: AES_ITER_BACK2BACK_EN -- when defined, a new block
// can be accepted on the same edge the previous ciphertext is handed off.
module aes_iter_ctrl
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [AES_BLK_W-1:0] in_data,
   input  logic [AES_BLK_W-1:0] in_key,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [AES_BLK_W-1:0] out_data,
   output logic                 busy,
   output logic [CNT_W-1:0]     round_idx
);

   state_e               fsm_q, fsm_d;
   logic [AES_BLK_W-1:0] state_q, state_d;
   logic [AES_BLK_W-1:0] key_q, key_d;
   logic [CNT_W-1:0]     round_q, round_d;

   logic [AES_BLK_W-1:0] sb, sr, mc, rk;
   logic                 accept;

   sub_byte  u_sub_byte  (.d_i(state_q), .d_o(sb));
   shift_row u_shift_row (.d_i(sb),      .d_o(sr));
   mix_col   u_mix_col   (.d_i(sr),      .d_o(mc));

   aes_key_step u_key_step (
      .key_i  (key_q),
      .rcon_i (rcon(round_q)),
      .key_o  (rk)
   );

   // Input side is closed while rst is high so nothing is taken in that cycle.
`ifdef AES_ITER_BACK2BACK_EN
   assign in_ready = ~rst & ((fsm_q == IDLE) | ((fsm_q == DONE) & out_ready));
`else
   assign in_ready = ~rst & (fsm_q == IDLE);
`endif

   assign accept    = in_valid & in_ready;
   assign out_valid = (fsm_q == DONE);
   assign out_data  = out_valid ? state_q : '0;
   assign busy      = (fsm_q == ROUND) | (fsm_q == DONE);
   assign round_idx = round_q;

   // Next-state: run one round per clock, hold the result until handed off,
   // and load a new block whenever one is accepted (IDLE, or DONE with handoff).
   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      unique case (fsm_q)
         IDLE: ;
         ROUND: begin
            key_d = rk;
            if (round_q == LAST_RND) begin
               state_d = sr ^ rk;
               round_d = '0;
               fsm_d   = DONE;
            end else begin
               state_d = mc ^ rk;
               round_d = round_q + CNT_W'(1);
            end
         end
         DONE: if (out_ready) fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
      if (accept) begin
         state_d = in_data ^ in_key;
         key_d   = in_key;
         round_d = CNT_W'(1);
         fsm_d   = ROUND;
      end
   end

   // State registers; reset discards any block in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         key_q   <= '0;
         round_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
      end
   end

endmodule

// File: tb/tb_aes_iter_ctrl.sv
// Bench for aes_iter_ctrl: FIPS-197 vectors, protocol corner cases and random
// blocks checked against a table-driven, fully expanded-key AES model.
module tb_aes_iter_ctrl;

   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] K_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] K_C  = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   logic         clk, rst, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] in_data, in_key, out_data;
   logic [3:0]   round_idx;
   int           checks, errors;

   aes_iter_ctrl dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_key(in_key), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy), .round_idx(round_idx)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] m2(input logic [7:0] a);
      return (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Reference: full key expansion first, then 10 rounds on a byte array.
   function automatic logic [127:0] ref_aes(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0]  w [44];
      logic [7:0]   st [16];
      logic [7:0]   t [16];
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {SBOX[tmp[23:16]], SBOX[tmp[15:8]], SBOX[tmp[7:0]], SBOX[tmp[31:24]]} ^ {rc, 24'h0};
            rc = m2(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) st[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) st[i] = SBOX[st[i]];
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r+4*c] = st[r+4*((c+r)%4)];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rnd < 10) begin
               st[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
               st[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
               st[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
               st[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
            end else begin
               st[4*c] = a0; st[4*c+1] = a1; st[4*c+2] = a2; st[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) st[i] = st[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = st[i];
      return res;
   endfunction

   // Offer one block for one cycle (caller checks in_ready beforehand).
   task automatic send(input logic [127:0] pt, input logic [127:0] k);
      in_valid = 1'b1; in_data = pt; in_key = k;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Counts cycles until out_valid; 40 means it never came.
   task automatic wait_out(output int cyc);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         @(negedge clk);
         cyc++;
      end
   endtask

   task automatic handoff();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
      checks++; if (out_data !== 128'h0) begin errors++; $display("FAIL rst_out_data: got %h exp 0", out_data); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b exp 0", busy); end
      checks++; if (round_idx !== 4'd0) begin errors++; $display("FAIL rst_round_idx: got %0d exp 0", round_idx); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b exp 1", in_ready); end
   endtask

   task automatic test_fips_b();
      int cyc;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fb_ready: got %b exp 1", in_ready); end
      send(PT_B, K_B);
      checks++; if (busy !== 1'b1 || round_idx !== 4'd1) begin errors++; $display("FAIL fb_start: busy %b rnd %0d exp 1 1", busy, round_idx); end
      wait_out(cyc);
      checks++; if (cyc != 10) begin errors++; $display("FAIL fb_latency: got %0d exp 10", cyc); end
      checks++; if (out_data !== CT_B) begin errors++; $display("FAIL fb_data: got %h exp %h", out_data, CT_B); end
      checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL fb_done: ready %b busy %b exp 0 1", in_ready, busy); end
      handoff();
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL fb_idle: valid %b busy %b ready %b exp 0 0 1", out_valid, busy, in_ready); end
   endtask

   task automatic test_fips_c();
      send(PT_C, K_C);
      for (int k = 1; k <= 10; k++) begin
         checks++; if (round_idx !== 4'(k)) begin errors++; $display("FAIL fc_round: got %0d exp %0d", round_idx, k); end
         @(negedge clk);
      end
      checks++; if (round_idx !== 4'd0 || out_valid !== 1'b1) begin errors++; $display("FAIL fc_done: rnd %0d valid %b exp 0 1", round_idx, out_valid); end
      checks++; if (out_data !== CT_C) begin errors++; $display("FAIL fc_data: got %h exp %h", out_data, CT_C); end
      handoff();
   endtask

   task automatic test_backpressure();
      int cyc;
      send(PT_B, K_B);
      wait_out(cyc);
      for (int k = 0; k < 5; k++) begin
         in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom}; in_key = {$urandom, $urandom, $urandom, $urandom};
         checks++; if (out_valid !== 1'b1 || out_data !== CT_B || in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_hold: valid %b data %h ready %b exp 1 %h 0", out_valid, out_data, in_ready, CT_B); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (out_data !== CT_B) begin errors++; $display("FAIL bp_data: got %h exp %h", out_data, CT_B); end
      handoff();
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: valid %b ready %b exp 0 1", out_valid, in_ready); end
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL idle_out_ready: valid %b busy %b exp 0 0", out_valid, busy); end
      end
      out_ready = 1'b0;
   endtask

   task automatic test_busy_ignore();
      send(PT_B, K_B);
      for (int k = 1; k <= 10; k++) begin
         in_valid = 1'($urandom_range(0, 1));
         in_data = {$urandom, $urandom, $urandom, $urandom}; in_key = {$urandom, $urandom, $urandom, $urandom};
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bi_ready: got %b exp 0 at round %0d", in_ready, k); end
         @(negedge clk);
      end
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1 || out_data !== CT_B) begin errors++; $display("FAIL bi_data: valid %b data %h exp 1 %h", out_valid, out_data, CT_B); end
      handoff();
   endtask

   task automatic test_reset_mid();
      int cyc;
      send(PT_B, K_B);
      repeat (4) @(negedge clk);
      checks++; if (round_idx !== 4'd5) begin errors++; $display("FAIL rm_round5: got %0d exp 5", round_idx); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || round_idx !== 4'd0 || in_ready !== 1'b0) begin
         errors++; $display("FAIL rm_reset: valid %b busy %b rnd %0d ready %b exp 0 0 0 0", out_valid, busy, round_idx, in_ready); end
      rst = 1'b0;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rm_ready: got %b exp 1", in_ready); end
      send(PT_C, K_C);
      wait_out(cyc);
      checks++; if (cyc != 10 || out_data !== CT_C) begin errors++; $display("FAIL rm_data: lat %0d data %h exp 10 %h", cyc, out_data, CT_C); end
      handoff();
   endtask

   task automatic test_random();
      int cyc;
      logic [127:0] pt, k, exp;
      for (int n = 0; n < 16; n++) begin
         pt = {$urandom, $urandom, $urandom, $urandom};
         k  = {$urandom, $urandom, $urandom, $urandom};
         exp = ref_aes(pt, k);
         send(pt, k);
         wait_out(cyc);
         checks++; if (cyc != 10 || out_data !== exp) begin errors++; $display("FAIL rand_%0d: lat %0d data %h exp 10 %h", n, cyc, out_data, exp); end
         repeat ($urandom_range(0, 3)) @(negedge clk);
         handoff();
      end
   endtask

   task automatic test_back_to_back();
      int c1, c2;
      send(PT_B, K_B);
      wait_out(c1);
      checks++; if (c1 != 10 || out_data !== CT_B) begin errors++; $display("FAIL b2b_first: lat %0d data %h exp 10 %h", c1, out_data, CT_B); end
      in_valid = 1'b1; in_data = PT_C; in_key = K_C; out_ready = 1'b1;
`ifdef AES_ITER_BACK2BACK_EN
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b exp 1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (busy !== 1'b1 || round_idx !== 4'd1 || out_valid !== 1'b0) begin
         errors++; $display("FAIL b2b_accept: busy %b rnd %0d valid %b exp 1 1 0", busy, round_idx, out_valid); end
      wait_out(c2);
      checks++; if (c2 + 1 != 11) begin errors++; $display("FAIL b2b_spacing: got %0d exp 11", c2 + 1); end
      checks++; if (out_data !== CT_C) begin errors++; $display("FAIL b2b_second: got %h exp %h", out_data, CT_C); end
`else
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL nob2b_ready: got %b exp 0", in_ready); end
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0;
      checks++; if (busy !== 1'b0 || round_idx !== 4'd0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL nob2b_idle: busy %b rnd %0d ready %b exp 0 0 1", busy, round_idx, in_ready); end
      send(PT_C, K_C);
      wait_out(c2);
      checks++; if (c2 != 10 || out_data !== CT_C) begin errors++; $display("FAIL nob2b_second: lat %0d data %h exp 10 %h", c2, out_data, CT_C); end
`endif
      handoff();
   endtask

   initial begin
      checks = 0; errors = 0;
      clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_key = '0;
      test_reset();
      test_fips_b();
      test_fips_c();
      test_backpressure();
      test_busy_ignore();
      test_reset_mid();
      test_random();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
